call_request_register: RTL
==========================

// Module: call_request_register
// PURPOSE
//  Clocked, parametrised successor to the elevator button latch. Conditions raw car and hall
//  buttons (sync, optional debounce, rising edge), latches pending calls, cancels car calls on
//  a second press, and clears calls when the controller reports a floor served. Also reports
//  request-direction summaries against the current floor. Sits between the button pads and
//  the elevator controller FSM.
// PARAMETERS
//  FLOORS           8   number of floors/buttons per bank (2..32)
//  DEBOUNCE_CYCLES  16  consecutive stable cycles before a level change is accepted (>=2)
//  FLOOR_W          localparam = $clog2(FLOORS); CNT_W localparam = $clog2(3*FLOORS+1)
// PORTS
//  clk             in   1        single clock; all logic on posedge
//  reset           in   1        synchronous, active-high reset
//  btn_car         in   FLOORS   raw in-car floor buttons, async
//  btn_hall_up     in   FLOORS   raw hall up buttons; bit FLOORS-1 ignored (no up at top)
//  btn_hall_down   in   FLOORS   raw hall down buttons; bit 0 ignored (no down at bottom)
//  blocked_vld     in   1        a floor is out of service
//  blocked_floor   in   FLOOR_W  index of the out-of-service floor
//  current_floor   in   FLOOR_W  cabin position from controller
//  served_vld      in   1        one-cycle pulse: cabin stopped with doors open at served_floor
//  served_floor    in   FLOOR_W  floor being served
//  served_dir      in   2        [0]=clear hall up, [1]=clear hall down at served_floor
//  car_req         out  FLOORS   latched car calls
//  hall_up_req     out  FLOORS   latched hall up calls
//  hall_down_req   out  FLOORS   latched hall down calls
//  req_count       out  CNT_W    registered popcount of all three vectors
//  req_above       out  1        any call at floor > current_floor (combinational from latches)
//  req_below       out  1        any call at floor < current_floor
//  req_here        out  1        any call at current_floor
// BEHAVIOUR
//  - Reset: all outputs, latches, sync flops, debounce counters, stable levels = 0.
//  - Conditioning per raw bit: 2-flop sync -> debounce -> stable level; press = stable 0->1.
//  - Latency: input high sampled at edge N -> latch visible after edge N+DEBOUNCE_CYCLES+3.
//  - Debounce: counter runs while synced level != stable; resets to 0 on any mismatch drop;
//    stable flips when counter hits DEBOUNCE_CYCLES-1. Glitch shorter than that: no effect.
//  - Car press at floor f: toggles car_req[f] (set if 0, cancel if 1).
//  - Hall press: sets bit; second press has no effect. Masked bits (up top, down bottom) stay 0.
//  - Blocked: presses for blocked_floor ignored while blocked_vld=1; existing latches for
//    that floor are cleared on the first blocked cycle and held 0 while blocked.
//  - served_vld: clears car_req[served_floor] plus hall bits selected by served_dir, next edge.
//  - Simultaneous press and serve on same bit in same cycle: clear wins (bit ends 0).
//  - served_floor / blocked_floor >= FLOORS: ignored, no state change.
//  - req_count registered with latches (same edge); never exceeds 3*FLOORS-2.
//  - Button held through reset: after reset release treated as new press (stable starts 0).
//  - Reset mid-debounce: counter cleared, pending change discarded.
// CONFIGURATION
//  CALL_DEBOUNCE_EN defined: debounce counters as above.
//  CALL_DEBOUNCE_EN undefined: no counters; stable = synced level; latency = 3 edges;
//    DEBOUNCE_CYCLES unused.
// STRUCTURE
//  - elevator_pkg: FLOORS default, floor_t, dir_e (DIR_UP=0, DIR_DOWN=1), served_dir bit consts.
//  - Sub-module btn_conditioner (one bit: sync, optional debounce, press pulse), instanced
//    3*FLOORS times via generate; latch/serve/count logic in this module.
// TESTING
//  1 Reset, car button 3 held 40 cycles (DEB=16) -> car_req=8'h08 at edge N+19, count=1.
//  2 Press car 3 again -> car_req=0, count=0; 10-cycle glitch on car 5 -> no change.
//  3 hall_up[7] and hall_down[0] pressed -> both vectors stay 0; hall_up[2] -> 8'h04.
//  4 hall_up[2] latched, served_vld floor 2 dir=2'b10 -> up stays; dir=2'b01 -> cleared.
//  5 Press car 4 arriving same cycle as served_vld floor 4 -> car_req[4]=0.
//  6 blocked floor 6 with car_req[6]=1 -> cleared; press 6 ignored; current_floor=3, car 1
//    -> req_below=1, req_above=0, req_here=0; repeat with macro off, latency 3.

Source files
------------

// File: rtl/call_request_register_pkg.sv
// Shared types and constants for the elevator call-request block.
// Build option: CALL_DEBOUNCE_EN enables per-button debounce counters.
package call_request_register_pkg;

  localparam int FLOORS_DEF  = 8;
  localparam int FLOOR_W_DEF = $clog2(FLOORS_DEF);

  typedef logic [FLOOR_W_DEF-1:0] floor_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // served_dir encodings: bit DIR_UP clears hall up, bit DIR_DOWN clears hall down
  localparam logic [1:0] SERVE_UP   = 2'b01;
  localparam logic [1:0] SERVE_DOWN = 2'b10;

endpackage

// File: rtl/call_request_register_if.sv
// Button-pad / controller bundle for call_request_register.
// master = pads + controller side, slave = the call-request register.
interface call_request_register_if
  import call_request_register_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF
);
  localparam int FLOOR_W = $clog2(FLOORS);
  localparam int CNT_W   = $clog2(3*FLOORS+1);

  logic [FLOORS-1:0]  btn_car;
  logic [FLOORS-1:0]  btn_hall_up;
  logic [FLOORS-1:0]  btn_hall_down;
  logic               blocked_vld;
  logic [FLOOR_W-1:0] blocked_floor;
  logic [FLOOR_W-1:0] current_floor;
  logic               served_vld;
  logic [FLOOR_W-1:0] served_floor;
  logic [1:0]         served_dir;

  logic [FLOORS-1:0]  car_req;
  logic [FLOORS-1:0]  hall_up_req;
  logic [FLOORS-1:0]  hall_down_req;
  logic [CNT_W-1:0]   req_count;
  logic               req_above;
  logic               req_below;
  logic               req_here;

  modport master (
    output btn_car, btn_hall_up, btn_hall_down,
    output blocked_vld, blocked_floor, current_floor,
    output served_vld, served_floor, served_dir,
    input  car_req, hall_up_req, hall_down_req,
    input  req_count, req_above, req_below, req_here
  );

  modport slave (
    input  btn_car, btn_hall_up, btn_hall_down,
    input  blocked_vld, blocked_floor, current_floor,
    input  served_vld, served_floor, served_dir,
    output car_req, hall_up_req, hall_down_req,
    output req_count, req_above, req_below, req_here
  );

endinterface

// File: rtl/call_request_register_btn_conditioner.sv
// One raw button bit: 2-flop synchroniser, optional debounce, registered rising-edge pulse.
// Build option: CALL_DEBOUNCE_EN inserts the stable-level debounce counter.
module btn_conditioner
`ifdef CALL_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;
  logic stable;

`ifdef CALL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stable_q;
  logic          stable_d;

  // Any cycle where the synced level agrees with stable restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= stable;
      press_q <= stable & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/call_request_register.sv
// Latches car/hall calls from conditioned buttons, clears them on serve/block, summarises direction.
// Build option: CALL_DEBOUNCE_EN enables debounce in every btn_conditioner instance.
module call_request_register
  import call_request_register_pkg::*;
#(
  parameter int FLOORS          = FLOORS_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  call_request_register_if.slave bus
);

  localparam int FLOOR_W = $clog2(FLOORS);
  localparam int CNT_W   = $clog2(3*FLOORS+1);

  localparam logic [FLOORS-1:0] ONE     = FLOORS'(1);
  localparam logic [FLOORS-1:0] UP_MASK = ~(ONE << (FLOORS-1));
  localparam logic [FLOORS-1:0] DN_MASK = ~ONE;

  if (FLOORS < 2 || FLOORS > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("call_request_register: FLOORS must be 2..32 and DEBOUNCE_CYCLES >= 2");
  end

  logic [FLOORS-1:0] car_press;
  logic [FLOORS-1:0] up_press;
  logic [FLOORS-1:0] dn_press;

  for (genvar f = 0; f < FLOORS; f++) begin : g_btn
    btn_conditioner
`ifdef CALL_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_car (.clk(clk), .rst(reset), .btn_i(bus.btn_car[f]), .press_o(car_press[f]));

    btn_conditioner
`ifdef CALL_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_up (.clk(clk), .rst(reset), .btn_i(bus.btn_hall_up[f]), .press_o(up_press[f]));

    btn_conditioner
`ifdef CALL_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_dn (.clk(clk), .rst(reset), .btn_i(bus.btn_hall_down[f]), .press_o(dn_press[f]));
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [FLOORS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < FLOORS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  logic [FLOORS-1:0] car_q, car_d;
  logic [FLOORS-1:0] up_q,  up_d;
  logic [FLOORS-1:0] dn_q,  dn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [FLOORS-1:0] serve_m;
  logic [FLOORS-1:0] blk_m;
  logic [FLOORS-1:0] clr_up;
  logic [FLOORS-1:0] clr_dn;

  // Out-of-range floor indices shift the one-hot off the top and select nothing.
  // Clears are applied after the press terms so a same-cycle serve or block always wins.
  always_comb begin
    serve_m = bus.served_vld  ? (ONE << bus.served_floor)  : '0;
    blk_m   = bus.blocked_vld ? (ONE << bus.blocked_floor) : '0;
    clr_up  = |(bus.served_dir & SERVE_UP)   ? serve_m : '0;
    clr_dn  = |(bus.served_dir & SERVE_DOWN) ? serve_m : '0;

    car_d = (car_q ^ car_press) & ~serve_m & ~blk_m;
    up_d  = (up_q  | up_press)  & ~clr_up  & ~blk_m & UP_MASK;
    dn_d  = (dn_q  | dn_press)  & ~clr_dn  & ~blk_m & DN_MASK;
    cnt_d = popcount(car_d) + popcount(up_d) + popcount(dn_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
      cnt_q <= '0;
    end else begin
      car_q <= car_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
      cnt_q <= cnt_d;
    end
  end

  logic [FLOORS-1:0] any_req;
  logic              above;
  logic              below;
  logic              here;

  always_comb begin
    any_req = car_q | up_q | dn_q;
    above   = 1'b0;
    below   = 1'b0;
    here    = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (FLOOR_W'(f) > bus.current_floor) begin
        above = above | any_req[f];
      end else if (FLOOR_W'(f) < bus.current_floor) begin
        below = below | any_req[f];
      end else begin
        here = here | any_req[f];
      end
    end
  end

  assign bus.car_req       = car_q;
  assign bus.hall_up_req   = up_q;
  assign bus.hall_down_req = dn_q;
  assign bus.req_count     = cnt_q;
  assign bus.req_above     = above;
  assign bus.req_below     = below;
  assign bus.req_here      = here;

endmodule
